// File: rtl/apb_axi_fill_engine.sv
// APB-programmed AXI4 write-burst fill engine (hardware memset), one burst in flight.
// Define FILL_ENGINE_INCREMENT_EN to make each beat carry PATTERN + running beat index.
module apb_axi_fill_engine #(
  parameter int C_APB_ADDR_BITS    = 16,
  parameter int C_M_AXI_ID_WIDTH   = 2,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_BURST        = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  output logic                            BUSY,
  output logic                            INTR,
  input  logic                            S_PSEL,
  input  logic                            S_PENABLE,
  input  logic                            S_PWRITE,
  input  logic [C_APB_ADDR_BITS-1:0]      S_PADDR,
  input  logic [31:0]                     S_PWDATA,
  output logic [31:0]                     S_PRDATA,
  output logic                            S_PREADY,
  output logic                            S_PSLVERR,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [7:0]                      M_AWLEN,
  output logic [2:0]                      M_AWSIZE,
  output logic [1:0]                      M_AWBURST,
  output logic                            M_AWLOCK,
  output logic [3:0]                      M_AWCACHE,
  output logic [2:0]                      M_AWPROT,
  output logic [3:0]                      M_AWREGION,
  output logic [3:0]                      M_AWQOS,
  output logic                            M_AWVALID,
  input  logic                            M_AWREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_WID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                            M_WLAST,
  output logic                            M_WVALID,
  input  logic                            M_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_BID,
  input  logic [1:0]                      M_BRESP,
  input  logic                            M_BVALID,
  output logic                            M_BREADY
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int LANES = C_M_AXI_DATA_WIDTH / 32;

  typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_AW, ST_W, ST_B, ST_FIN} state_t;

  state_t          state;
  logic            irq_en, done, err;
  logic [31:0]     dst_addr, beats, pattern, remaining;
  logic [AW-1:0]   addr;
  logic [8:0]      len, beat_cnt;
  logic            aw_valid, w_valid, w_last, b_ready;
  logic [31:0]     beat_word;

  logic [4:0]  off;
  logic        acc, mapped, wr, busy, start;
  logic [31:0] rdata;

  assign off    = S_PADDR[4:0];
  assign acc    = S_PSEL & S_PENABLE;
  assign mapped = (off == 5'h00) | (off == 5'h04) | (off == 5'h08) | (off == 5'h0C) | (off == 5'h10);
  assign wr     = acc & S_PWRITE & mapped;
  assign busy   = (state != ST_IDLE);
  assign start  = wr & (off == 5'h00) & S_PWDATA[0] & ~busy;

  always_comb begin
    rdata = '0;
    case (off)
      5'h00:   rdata = {30'b0, irq_en, 1'b0};
      5'h04:   rdata = {29'b0, err, done, busy};
      5'h08:   rdata = dst_addr;
      5'h0C:   rdata = beats;
      5'h10:   rdata = pattern;
      default: rdata = '0;
    endcase
  end

  assign S_PRDATA  = (acc & ~S_PWRITE & mapped) ? rdata : 32'h0;
  assign S_PSLVERR = acc & ~mapped;
  assign S_PREADY  = 1'b1;
  assign BUSY      = busy;
  assign INTR      = done & irq_en;

  // Burst length: clipped by remaining beats, max burst and the next 4KB page edge.
  logic [12:0] to_page;
  logic [31:0] page_beats, cap;
  logic [8:0]  next_len;
  assign to_page    = 13'h1000 - {1'b0, addr[11:0]};
  assign page_beats = 32'(to_page >> SZ);
  assign cap        = (page_beats < 32'(C_MAX_BURST)) ? page_beats : 32'(C_MAX_BURST);
  assign next_len   = (remaining < cap) ? remaining[8:0] : cap[8:0];

`ifdef FILL_ENGINE_INCREMENT_EN
  logic [31:0] fill_idx;
  assign beat_word = pattern + fill_idx;
`else
  assign beat_word = pattern;
`endif

  assign M_AWID     = '0;
  assign M_AWADDR   = addr;
  assign M_AWLEN    = 8'(len - 9'd1);
  assign M_AWSIZE   = 3'(SZ);
  assign M_AWBURST  = 2'b01;
  assign M_AWLOCK   = 1'b0;
  assign M_AWCACHE  = 4'b0011;
  assign M_AWPROT   = 3'b000;
  assign M_AWREGION = 4'b0000;
  assign M_AWQOS    = 4'b0000;
  assign M_AWVALID  = aw_valid;
  assign M_WID      = '0;
  assign M_WDATA    = {LANES{beat_word}};
  assign M_WSTRB    = '1;
  assign M_WLAST    = w_last;
  assign M_WVALID   = w_valid;
  assign M_BREADY   = b_ready;

  logic unused_ok;
  assign unused_ok = ^{M_BID, S_PADDR};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dst_addr  <= '0;
      beats     <= '0;
      pattern   <= '0;
      remaining <= '0;
      addr      <= '0;
      len       <= '0;
      beat_cnt  <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      b_ready   <= 1'b0;
`ifdef FILL_ENGINE_INCREMENT_EN
      fill_idx  <= '0;
`endif
    end else begin
      if (wr) begin
        case (off)
          5'h00: irq_en <= S_PWDATA[1];
          5'h04: begin
            if (S_PWDATA[1]) done <= 1'b0;
            if (S_PWDATA[2]) err  <= 1'b0;
          end
          5'h08: if (!busy) dst_addr <= S_PWDATA;
          5'h0C: if (!busy) beats    <= S_PWDATA;
          5'h10: if (!busy) pattern  <= S_PWDATA;
          default: ;
        endcase
      end
      // FSM updates follow the register writes so hardware sets beat W1C clears.
      case (state)
        ST_IDLE: if (start) begin
          done      <= 1'b0;
          err       <= 1'b0;
          addr      <= AW'(dst_addr) & ~AW'(BYTES - 1);
          remaining <= beats;
`ifdef FILL_ENGINE_INCREMENT_EN
          fill_idx  <= '0;
`endif
          state     <= ST_CALC;
        end
        ST_CALC: if (remaining == 32'd0) state <= ST_FIN;
        else begin
          len      <= next_len;
          aw_valid <= 1'b1;
          state    <= ST_AW;
        end
        ST_AW: if (M_AWREADY) begin
          aw_valid <= 1'b0;
          w_valid  <= 1'b1;
          w_last   <= (len == 9'd1);
          beat_cnt <= '0;
          state    <= ST_W;
        end
        ST_W: if (M_WREADY) begin
          beat_cnt <= beat_cnt + 9'd1;
`ifdef FILL_ENGINE_INCREMENT_EN
          fill_idx <= fill_idx + 32'd1;
`endif
          if (w_last) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            b_ready <= 1'b1;
            state   <= ST_B;
          end else begin
            w_last  <= (beat_cnt + 9'd2 == len);
          end
        end
        ST_B: if (M_BVALID) begin
          b_ready <= 1'b0;
          if (M_BRESP == 2'b00) begin
            addr      <= addr + (AW'(len) << SZ);
            remaining <= remaining - 32'(len);
            state     <= ST_CALC;
          end else begin
            err   <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
